// File: rtl/lock_pkg.sv
// Shared lock-protocol definitions: FSM state encoding, default code,
// serial idle level and a saturating-increment helper.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLR       = 3'd1,
    SHIFT     = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4,
    FAIL      = 3'd5
  } lock_state_t;

  localparam logic [2:0] LOCK_CODE_DEFAULT  = 3'b010;
  localparam logic       IDLE_LEVEL_DEFAULT = 1'b1;

  function automatic int unsigned sat_inc(
    input int unsigned v,
    input int unsigned max
  );
    return (v >= max) ? v : v + 1;
  endfunction

endpackage

// File: rtl/lock_code_shifter.sv
// MSB-first parallel-in serial-out register for the unlock code.
// Ports: clk, rst (sync, high), load (capture data, point at MSB),
//   rewind (point at MSB again, keep code), advance (step to next bit),
//   data (code), bit_out (current bit), last (every bit already issued).
module lock_code_shifter
  import lock_pkg::*;
#(
  parameter int CODE_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                rewind,
  input  logic                advance,
  input  logic [CODE_LEN-1:0] data,
  output logic                bit_out,
  output logic                last
);

  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [IW-1:0] TOP = IW'(CODE_LEN - 1);

  logic [CODE_LEN-1:0] code_q;
  logic [IW-1:0]       idx;

  // The code itself is never destroyed, so a retry only rewinds idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      idx    <= TOP;
      last   <= 1'b1;
    end else if (load) begin
      code_q <= data;
      idx    <= TOP;
      last   <= 1'b0;
    end else if (rewind) begin
      idx  <= TOP;
      last <= 1'b0;
    end else if (advance && !last) begin
      if (idx == '0) last <= 1'b1;
      else           idx  <= idx - 1'b1;
    end
  end

  assign bit_out = code_q[idx];

endmodule

// File: rtl/lock_code_sender.sv
// Sends a stored unlock code serially to the lock FSM and reports the
// LockSys/Alarm outcome via a start/busy/done handshake.
// Ports: CLK, RESET (sync, high), start, code_in, lock_ok, alarm ->
//   serial_out, lock_clr, busy, done, result_ok, attempts.
// Optional: define LOCK_RETRY_EN to retry failed attempts up to MAX_RETRY.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int       CODE_LEN     = 3,
  parameter int       RESP_TIMEOUT = 4,
  parameter logic     IDLE_LEVEL   = IDLE_LEVEL_DEFAULT,
  parameter int       MAX_RETRY    = 2,
  parameter int       CNT_W        = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code_in,
  input  logic                lock_ok,
  input  logic                alarm,
  output logic                serial_out,
  output logic                lock_clr,
  output logic                busy,
  output logic                done,
  output logic                result_ok,
  output logic [CNT_W-1:0]    attempts
);

  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(RESP_TIMEOUT - 1);
  localparam int unsigned AMAX = (1 << CNT_W) - 1;

  lock_state_t   state;
  logic [TW-1:0] tcnt;
  logic          sh_bit;
  logic          sh_last;
  logic          under_limit;
  logic          retry_ok;
  logic          sh_load;
  logic          sh_rewind;
  logic          sh_adv;

  assign under_limit = 32'(attempts) <= MAX_RETRY;

`ifdef LOCK_RETRY_EN
  assign retry_ok = under_limit;
`else
  assign retry_ok = under_limit & 1'b0;
`endif

  assign sh_load   = (state == IDLE) && start;
  assign sh_rewind = (state == FAIL) && retry_ok;
  assign sh_adv    = (state == CLR) ||
                     ((state == SHIFT) && !sh_last);

  lock_code_shifter #(
    .CODE_LEN(CODE_LEN)
  ) u_shifter (
    .clk    (CLK),
    .rst    (RESET),
    .load   (sh_load),
    .rewind (sh_rewind),
    .advance(sh_adv),
    .data   (code_in),
    .bit_out(sh_bit),
    .last   (sh_last)
  );

  // Outputs are registered on the transition into the state they belong to.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      serial_out <= IDLE_LEVEL;
      lock_clr   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result_ok  <= 1'b0;
      attempts   <= '0;
      tcnt       <= '0;
    end else begin
      lock_clr <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            attempts  <= CNT_W'(1);
            busy      <= 1'b1;
            result_ok <= 1'b0;
            lock_clr  <= 1'b1;
            state     <= CLR;
          end
        end
        CLR: begin
          serial_out <= sh_bit;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (sh_last) begin
            serial_out <= IDLE_LEVEL;
            tcnt       <= '0;
            state      <= WAIT_RESP;
          end else begin
            serial_out <= sh_bit;
          end
        end
        WAIT_RESP: begin
          if (lock_ok) begin
            done      <= 1'b1;
            result_ok <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else if (alarm || tcnt == TLAST) begin
            state <= FAIL;
            // Only the final failure ends the transaction.
            if (!retry_ok) begin
              done      <= 1'b1;
              result_ok <= 1'b0;
              busy      <= 1'b0;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        FAIL: begin
          if (retry_ok) begin
            attempts <= CNT_W'(sat_inc(32'(attempts), AMAX));
            lock_clr <= 1'b1;
            state    <= CLR;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender: reset, unlock, alarm, timeout,
// simultaneous response, ignored start and mid-transaction reset.
module tb_lock_code_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] code_in = 3'b000;
  logic       lock_ok = 1'b0;
  logic       alarm = 1'b0;
  logic       serial_out;
  logic       lock_clr;
  logic       busy;
  logic       done;
  logic       result_ok;
  logic [1:0] attempts;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lock_code_sender dut (
    .CLK       (clk),
    .RESET     (rst),
    .start     (start),
    .code_in   (code_in),
    .lock_ok   (lock_ok),
    .alarm     (alarm),
    .serial_out(serial_out),
    .lock_clr  (lock_clr),
    .busy      (busy),
    .done      (done),
    .result_ok (result_ok),
    .attempts  (attempts)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // resp: 0 lock_ok, 1 alarm, 2 silence, 3 both; ph counts from lock_clr
  task automatic run_txn(input string tag,
                         input logic [2:0] code,
                         input int resp,
                         input int glitch,
                         input int exp_clr,
                         input int exp_done,
                         input logic exp_ok,
                         input int exp_att);
    int clr_n = 0;
    int ph = -1;
    int done_at = -1;
    int busy_bad = 0;
    code_in = code;
    start = 1'b1;
    step();
    start = 1'b0;
    code_in = 3'b000;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      if (lock_clr) begin
        clr_n++;
        ph = 0;
      end else if (ph >= 0) begin
        ph++;
      end
      if (ph >= 1 && ph <= 3)
        chk({tag, "_bit"}, 32'(serial_out), 32'(code[3-ph]));
      if (ph == 4)
        chk({tag, "_idle"}, 32'(serial_out), 32'd1);
      lock_ok = (ph == 4) && (resp == 0 || resp == 3);
      alarm   = (ph == 4) && (resp == 1 || resp == 3);
      start   = (glitch != 0) && (c == 3);
      code_in = start ? ~code : 3'b000;
      if (done) begin
        done_at = c;
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      end else begin
        if (busy !== 1'b1) busy_bad++;
        step();
      end
    end
    lock_ok = 1'b0;
    alarm = 1'b0;
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_done_cyc"}, 32'(done_at), 32'(exp_done));
    chk({tag, "_clr_n"}, 32'(clr_n), 32'(exp_clr));
    chk({tag, "_ok"}, 32'(result_ok), 32'(exp_ok));
    chk({tag, "_att"}, 32'(attempts), 32'(exp_att));
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ok_hold"}, 32'(result_ok), 32'(exp_ok));
    step();
    step();
    chk({tag, "_no_clr"}, 32'(lock_clr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1;
    step();
    step();
    chk("rst_serial", 32'(serial_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_clr", 32'(lock_clr), 32'd0);
    chk("rst_ok", 32'(result_ok), 32'd0);
    chk("rst_att", 32'(attempts), 32'd0);
    rst = 1'b0;
    step();

    run_txn("unlock", 3'b010, 0, 0, 1, 6, 1'b1, 1);
`ifdef LOCK_RETRY_EN
    run_txn("alarm", 3'b010, 1, 0, 3, 18, 1'b0, 3);
    run_txn("tmo", 3'b011, 2, 0, 3, 27, 1'b0, 3);
`else
    run_txn("alarm", 3'b010, 1, 0, 1, 6, 1'b0, 1);
    run_txn("tmo", 3'b011, 2, 0, 1, 9, 1'b0, 1);
`endif
    run_txn("both", 3'b101, 3, 0, 1, 6, 1'b1, 1);
    run_txn("glitch", 3'b110, 0, 1, 1, 6, 1'b1, 1);

    code_in = 3'b010;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_inshift", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_serial", 32'(serial_out), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_att", 32'(attempts), 32'd0);
    chk("mid_ok", 32'(result_ok), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || lock_clr !== 1'b0)
        bad++;
    end
    chk("mid_quiet", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
